// File: rtl/mat_pkg.sv
// Shared constants and FSM state encoding for the matrix-multiply result path.
package mat_pkg;

  localparam int DATA_W = 22;
  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry FIFO whose head entry is held in registers that drive the stream outputs directly.
module result_skid_fifo #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;
  logic             r_valid;

  // The head stays untouched unless it is popped, so the outputs hold while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_count)
        2'd0: begin
          if (i_push) begin
            r_head  <= i_data;
            r_count <= 2'd1;
            r_valid <= 1'b1;
          end
        end
        2'd1: begin
          if (i_push && i_pop) begin
            r_head <= i_data;
          end else if (i_push) begin
            r_tail  <= i_data;
            r_count <= 2'd2;
          end else if (i_pop) begin
            r_count <= 2'd0;
            r_valid <= 1'b0;
          end
        end
        default: begin
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) begin
              r_tail <= i_data;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/mat_result_streamer.sv
// Drains MEM_C in address order after done and streams each word out on a valid/ready port.
module mat_result_streamer
  import mat_pkg::*;
#(
  parameter int DATA_W = mat_pkg::DATA_W,
  parameter int DEPTH  = mat_pkg::DEPTH,
  parameter int ADDR_W = mat_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              done,
  output logic              mem_cs,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              drain_done
);

  localparam int                FIFO_W      = DATA_W + ADDR_W;
  localparam logic [ADDR_W:0]   LP_DEPTH    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LP_LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_idx;
  logic              r_busy;
  logic              r_drain_done;

  logic [FIFO_W-1:0] w_head;
  logic              w_fifo_valid;
  logic [1:0]        w_fifo_count;
  logic              w_pop;
  logic [2:0]        w_used;
  logic              w_credit_ok;
  logic              w_issue;
  logic              w_final;

  assign w_pop  = w_fifo_valid & out_ready;
  assign w_used = {1'b0, w_fifo_count} + {2'b00, r_inflight};

  // A word leaving this cycle frees one slot, so a read may still be issued into a full FIFO.
  assign w_credit_ok = (w_used < (w_pop ? 3'd3 : 3'd2));
  assign w_issue     = (r_state == ST_STREAM) && (r_rd_ptr < LP_DEPTH) && w_credit_ok;

  assign w_final = (r_state == ST_FLUSH) && !r_inflight && (w_fifo_count == 2'd1) && w_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= ST_IDLE;
      r_rd_ptr       <= '0;
      r_inflight     <= 1'b0;
      r_inflight_idx <= '0;
      r_busy         <= 1'b0;
      r_drain_done   <= 1'b0;
    end else begin
      r_inflight   <= w_issue;
      r_drain_done <= 1'b0;
      if (w_issue) begin
        r_inflight_idx <= r_rd_ptr[ADDR_W-1:0];
      end
      case (r_state)
        ST_IDLE: begin
          // done arriving in the drain_done cycle belongs to the drain just finished.
          if (done && !r_drain_done) begin
            r_state  <= ST_STREAM;
            r_rd_ptr <= '0;
            r_busy   <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_rd_ptr == LP_LAST_PTR) begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (w_final) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_drain_done <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  result_skid_fifo #(
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .i_push (r_inflight),
    .i_data ({mem_rdata, r_inflight_idx}),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_valid(w_fifo_valid),
    .o_count(w_fifo_count)
  );

  assign mem_cs     = w_issue;
  assign mem_addr   = r_rd_ptr[ADDR_W-1:0];
  assign out_valid  = w_fifo_valid;
  assign out_data   = w_head[FIFO_W-1:ADDR_W];
  assign out_index  = w_head[ADDR_W-1:0];
  assign out_last   = w_fifo_valid && (out_index == LP_LAST_IDX);
  assign busy       = r_busy;
  assign drain_done = r_drain_done;

endmodule

// File: tb/tb_mat_result_streamer.sv
// Randomised scoreboard bench for mat_result_streamer: full-size drains plus a DEPTH=4 build.
module tb_mat_result_streamer;

  localparam int DW  = 22;
  localparam int D   = 4096;
  localparam int AW  = 12;
  localparam int SD  = 4;
  localparam int SAW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, done, out_ready;
  logic          mem_cs, out_valid, out_last, busy, drain_done;
  logic [AW-1:0] mem_addr, out_index;
  logic [DW-1:0] mem_rdata, out_data;
  logic [DW-1:0] mem [D];

  logic           s_done, s_ready;
  logic           s_cs, s_valid, s_last, s_busy, s_drain;
  logic [SAW-1:0] s_addr, s_index;
  logic [DW-1:0]  s_rdata, s_data;
  logic [DW-1:0]  s_mem [SD];

  always @(posedge clk) if (mem_cs) mem_rdata <= mem[mem_addr];
  always @(posedge clk) if (s_cs) s_rdata <= s_mem[s_addr];

  mat_result_streamer #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .done(done), .mem_cs(mem_cs), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .drain_done(drain_done));

  mat_result_streamer #(.DATA_W(DW), .DEPTH(SD), .ADDR_W(SAW)) dut_small (
    .clk(clk), .rstn(rstn), .done(s_done), .mem_cs(s_cs), .mem_addr(s_addr),
    .mem_rdata(s_rdata), .out_valid(s_valid), .out_ready(s_ready), .out_data(s_data),
    .out_index(s_index), .out_last(s_last), .busy(s_busy), .drain_done(s_drain));

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_drain  = 0;
  int   n_reads  = 0;
  int   cyc      = 0;
  int   drain_cyc = 0;
  bit   rdy_rand = 1'b0;
  bit   rdy_val  = 1'b1;
  int   rdy_pct  = 30;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Ready source: a fixed level or a random draw each cycle, changed just after the edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? ($urandom_range(0, 99) < rdy_pct) : rdy_val;
    end
  end

  // Monitor: pops the reference queue on each handshake and checks stall stability.
  initial begin
    bit   stall;
    exp_t held, got, e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall = 1'b0;
        continue;
      end
      got = {out_data, out_index, out_last};
      if (mem_cs) n_reads++;
      if (stall) check(out_valid && (got == held), "hold", {out_valid, got}, {1'b1, held});
      if (out_valid && out_ready) begin
        check(exp_q.size() > 0, "extra_word", got, 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check(got == e, "word", got, e);
        end
      end
      stall = out_valid && !out_ready;
      held  = got;
      if (drain_done) begin
        n_drain++;
        drain_cyc = cyc;
        check((exp_q.size() == 0) && !busy, "drain_done_empty", {busy, 32'(exp_q.size())}, 0);
      end
    end
  end

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < D; i++) mem[i] = rnd ? DW'($urandom) : DW'(i * 3);
  endtask

  // Reference model: a drain delivers every word in address order, last flagged on the top index.
  task automatic start_drain(output int c0);
    @(posedge clk);
    #1;
    check(!busy, "idle_before_start", busy, 0);
    done = 1'b1;
    for (int i = 0; i < D; i++) exp_q.push_back({mem[i], AW'(i), i == D - 1});
    @(posedge clk);
    #1;
    c0 = cyc;
    done = 1'b0;
    @(negedge clk);
    check(mem_cs && (mem_addr == 0) && busy, "first_read", {mem_cs, mem_addr, busy}, {1'b1, 12'd0, 1'b1});
    @(negedge clk);
    check(!out_valid, "no_valid_at_T1", out_valid, 0);
    @(negedge clk);
    check(out_valid && (out_index == 0), "first_valid_at_T2", {out_valid, out_index}, {1'b1, 12'd0});
  endtask

  task automatic wait_drain(input int budget, input int n_before);
    int k;
    k = 0;
    while ((n_drain == n_before) && (k < budget)) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(n_drain == n_before + 1, "drain_timeout", n_drain, n_before + 1);
    repeat (5) @(negedge clk);
    #1;
    check(n_drain == n_before + 1, "single_drain_done", n_drain, n_before + 1);
  endtask

  task automatic wait_index(input int idx);
    int k;
    k = 0;
    while (!(out_valid && (out_index == AW'(idx))) && (k < 20000)) begin
      @(negedge clk);
      k++;
    end
    check(out_valid && (out_index == AW'(idx)), "reach_index", out_index, idx);
  endtask

  initial begin
    int c0, nd, r0, k, sd;
    rstn    = 1'b0;
    done    = 1'b0;
    s_done  = 1'b0;
    s_ready = 1'b1;
    fill_mem(1'b0);
    repeat (3) @(posedge clk);
    #2;
    check({mem_cs, mem_addr, out_valid, out_data, out_index, out_last, busy, drain_done} == 0,
          "reset_state", {mem_cs, mem_addr, out_valid, out_data, out_index, out_last, busy, drain_done}, 0);
    rstn = 1'b1;

    // Full-speed drain and its exact cycle count.
    nd = n_drain;
    start_drain(c0);
    wait_drain(20000, nd);
    check(drain_cyc - c0 == D + 2, "drain_latency", drain_cyc - c0, D + 2);

    // Sparse ready: ordering, no loss, hold while stalled.
    rdy_rand = 1'b1;
    rdy_pct  = 30;
    nd = n_drain;
    start_drain(c0);
    wait_drain(30000, nd);
    rdy_rand = 1'b0;

    // Ready low from the start: reads stop once two words are buffered.
    rdy_val = 1'b0;
    @(posedge clk);
    @(posedge clk);
    nd = n_drain;
    #2;
    r0 = n_reads;
    start_drain(c0);
    repeat (18) @(negedge clk);
    #1;
    check((n_reads - r0 == 2) && !mem_cs, "stall_reads", {mem_cs, 32'(n_reads - r0)}, 2);
    check(out_valid && (out_index == 0), "stall_head", {out_valid, out_index}, {1'b1, 12'd0});
    rdy_val = 1'b1;
    wait_drain(20000, nd);

    // done re-pulsed mid-stream must be ignored.
    fill_mem(1'b1);
    nd = n_drain;
    start_drain(c0);
    wait_index(100);
    @(posedge clk);
    #1 done = 1'b1;
    @(posedge clk);
    #1 done = 1'b0;
    check(busy, "busy_after_redone", busy, 1);
    wait_drain(20000, nd);

    // Asynchronous reset mid-drain, then a fresh drain from index 0.
    fill_mem(1'b1);
    nd = n_drain;
    start_drain(c0);
    wait_index(2000);
    #2 rstn = 1'b0;
    #1;
    check({mem_cs, mem_addr, out_valid, out_data, out_index, out_last, busy, drain_done} == 0,
          "async_reset", {mem_cs, mem_addr, out_valid, out_data, out_index, out_last, busy, drain_done}, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
    check(!busy && !out_valid && (n_drain == nd), "idle_after_reset", {busy, out_valid, 32'(n_drain)}, nd);
    rdy_rand = 1'b1;
    rdy_pct  = 70;
    start_drain(c0);
    wait_drain(20000, nd);
    rdy_rand = 1'b0;

    // DEPTH=4 build: full-scale word and last flag on index 3.
    s_mem[0] = 22'h3FFFFF;
    s_mem[1] = 22'd0;
    s_mem[2] = 22'd1;
    s_mem[3] = 22'd2;
    @(posedge clk);
    #1 s_done = 1'b1;
    @(posedge clk);
    #1 s_done = 1'b0;
    k  = 0;
    sd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s_valid && s_ready) begin
        check((k < SD) && (s_data == s_mem[k % SD]) && (s_index == SAW'(k)) && (s_last == (k == SD - 1)),
              "small_word", {s_data, s_index, s_last}, {s_mem[k % SD], SAW'(k), k == SD - 1});
        k++;
      end
      if (s_drain) sd++;
    end
    check(k == SD, "small_count", k, SD);
    check(sd == 1, "small_drain_done", sd, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
